addsub_sched: RTL and testbench

Round-robin scheduler that shares one registered AddSub unit (1-cycle latency, no carry out) among NREQ requesters. Each requester presents operands plus an add/subtract select through a valid/ready handshake. The scheduler issues at most one operation per cycle into the shared unit and returns each result to its originator through a per-requester response handshake with backpressure. It sits between the arithmetic clients of a datapath and the single shared adder/subtractor.

---
 rtl/addsub_sched_pkg.sv | 19 +
 rtl/AddSub.sv | 23 ++
 rtl/addsub_sched_rr_arbiter.sv | 33 +++
 rtl/addsub_sched.sv | 89 ++++++++
 tb/tb_addsub_sched.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_sched_pkg.sv
// Shared constants and helpers for the add/sub scheduler:
// state encoding, index sizing and the requester-count limit.
package addsub_sched_pkg;

    localparam logic IDLE = 1'b0;
    localparam logic RESP = 1'b1;

    localparam int unsigned NREQ_MAX = 8;

    // Never returns 0, so a 1-bit index survives degenerate sizes.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/AddSub.sv
// Registered adder/subtractor shared by all requesters: S updates only when
// ClockEn is high, otherwise it holds. Active-high asynchronous reset.
module AddSub #(
    parameter int unsigned width = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ClockEn,
    input  logic             SubEn,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic [width-1:0] S
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            S <= '0;
        end else if (ClockEn) begin
            S <= SubEn ? (A + ~B + 1'b1) : (A + B);
        end
    end

endmodule

// File: rtl/addsub_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from Last+1 upward, wrapping
// modulo NREQ, and returns a one-hot grant plus its index.
module rr_arbiter
    import addsub_sched_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] Req,
    input  logic [IW-1:0]   Last,
    output logic [NREQ-1:0] Grant,
    output logic [IW-1:0]   GrantIdx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        Grant    = '0;
        GrantIdx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IW'((32'(Last) + k) % NREQ);
            if (!found && Req[idx]) begin
                found      = 1'b1;
                Grant[idx] = 1'b1;
                GrantIdx   = idx;
            end
        end
    end

endmodule

// File: rtl/addsub_sched.sv
// Round-robin scheduler sharing one registered AddSub among NREQ requesters,
// with per-requester response handshake and backpressure.
module addsub_sched
    import addsub_sched_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       ReqValid,
    input  logic [NREQ-1:0]       ReqSub,
    input  logic [NREQ*width-1:0] ReqA,
    input  logic [NREQ*width-1:0] ReqB,
    output logic [NREQ-1:0]       ReqReady,
    output logic [NREQ-1:0]       RspValid,
    output logic [width-1:0]      RspData,
    input  logic [NREQ-1:0]       RspReady,
    output logic                  Busy
);

    localparam int unsigned IW = clog2(NREQ);

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("addsub_sched: NREQ out of range");
    end

    logic             state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    last;
    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    grant_idx;
    logic             issue_ok;
    logic             issue;
    logic             sub_sel;
    logic [width-1:0] a_sel;
    logic [width-1:0] b_sel;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .Req     (ReqValid),
        .Last    (last),
        .Grant   (grant),
        .GrantIdx(grant_idx)
    );

    // Gated by Reset so no grant is offered while the block is held in reset.
    always_comb begin
        issue_ok = Reset && ((state == IDLE) || RspReady[owner]);
        issue    = issue_ok && (|ReqValid);
        ReqReady = issue_ok ? grant : '0;
        sub_sel  = ReqSub[grant_idx];
        a_sel    = ReqA[grant_idx*width +: width];
        b_sel    = ReqB[grant_idx*width +: width];
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(NREQ - 1);
        end else if (issue) begin
            state <= RESP;
            owner <= grant_idx;
            last  <= grant_idx;
        end else if (issue_ok) begin
            state <= IDLE;
        end
    end

    AddSub #(
        .width(width)
    ) u_addsub (
        .Clock  (Clock),
        .Reset  (~Reset),
        .ClockEn(issue),
        .SubEn  (sub_sel),
        .A      (a_sel),
        .B      (b_sel),
        .S      (RspData)
    );

    always_comb begin
        RspValid = (state == RESP) ? (NREQ'(1) << owner) : '0;
        Busy     = (state == RESP);
    end

endmodule

// File: tb/tb_addsub_sched.sv
// Scoreboard bench for addsub_sched: expected results are queued at issue
// and compared against RspValid/RspData every cycle.
module tb_addsub_sched;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [N-1:0]   ReqValid;
    logic [N-1:0]   ReqSub;
    logic [N*W-1:0] ReqA;
    logic [N*W-1:0] ReqB;
    logic [N-1:0]   ReqReady;
    logic [N-1:0]   RspValid;
    logic [W-1:0]   RspData;
    logic [N-1:0]   RspReady;
    logic           Busy;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
    } op_t;

    typedef struct {
        int unsigned  idx;
        logic [W-1:0] data;
    } exp_t;

    op_t          opq[N][$];
    exp_t         sb[$];
    logic [N-1:0] rsp_ready;
    logic [N-1:0] samp_ready;
    logic [W-1:0] samp_data;
    int unsigned  checks = 0;
    int unsigned  errors = 0;

    addsub_sched #(
        .width(W),
        .NREQ (N)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .ReqValid(ReqValid),
        .ReqSub  (ReqSub),
        .ReqA    (ReqA),
        .ReqB    (ReqB),
        .ReqReady(ReqReady),
        .RspValid(RspValid),
        .RspData (RspData),
        .RspReady(RspReady),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input op_t op);
        return op.sub ? W'(op.a - op.b) : W'(op.a + op.b);
    endfunction

    function automatic int unsigned pending();
        int unsigned n;
        n = sb.size();
        for (int unsigned i = 0; i < N; i++) n += opq[i].size();
        return n;
    endfunction

    task automatic push_op(input int unsigned i, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic sub);
        op_t o;
        o.a = a;
        o.b = b;
        o.sub = sub;
        opq[i].push_back(o);
    endtask

    task automatic clear_all();
        sb.delete();
        for (int unsigned i = 0; i < N; i++) opq[i].delete();
    endtask

    task automatic drive();
        for (int unsigned i = 0; i < N; i++) begin
            if (opq[i].size() > 0) begin
                ReqValid[i]     = 1'b1;
                ReqSub[i]       = opq[i][0].sub;
                ReqA[i*W +: W]  = opq[i][0].a;
                ReqB[i*W +: W]  = opq[i][0].b;
            end else begin
                ReqValid[i] = 1'b0;
            end
        end
        RspReady = rsp_ready;
    endtask

    // One clock: drive at negedge, sample mid-cycle, book-keep at posedge.
    task automatic tick();
        logic [N-1:0] acc;
        logic         pop;
        exp_t         e;
        drive();
        #1;
        samp_ready = ReqReady;
        samp_data  = RspData;
        check("ready_onehot", 32'($onehot0(ReqReady)), 32'd1);
        check("ready_subset", 32'(ReqReady & ~ReqValid), 32'd0);
        if (sb.size() > 0) begin
            check("rsp_valid", 32'(RspValid), 32'd1 << sb[0].idx);
            check("busy", 32'(Busy), 32'd1);
            check("rsp_data", 32'(RspData), 32'(sb[0].data));
            pop = RspReady[sb[0].idx];
        end else begin
            check("rsp_valid", 32'(RspValid), 32'd0);
            check("busy", 32'(Busy), 32'd0);
            pop = 1'b0;
        end
        acc = ReqValid & ReqReady;
        @(posedge Clock);
        if (pop) void'(sb.pop_front());
        for (int unsigned i = 0; i < N; i++) begin
            if (acc[i] && opq[i].size() > 0) begin
                e.idx  = i;
                e.data = model(opq[i][0]);
                sb.push_back(e);
                void'(opq[i].pop_front());
            end
        end
        @(negedge Clock);
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        clear_all();
        rsp_ready = '0;
        drive();
        @(negedge Clock);
        #1;
        check("rst_valid", 32'(RspValid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_data", 32'(RspData), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic drain();
        rsp_ready = '1;
        for (int unsigned k = 0; k < 60 && pending() > 0; k++) tick();
        check("drain_empty", pending(), 32'd0);
    endtask

    initial begin
        Reset     = 1'b0;
        ReqValid  = '0;
        ReqSub    = '0;
        ReqA      = '0;
        ReqB      = '0;
        RspReady  = '0;
        rsp_ready = '0;

        // Full load: all four requesting while still in reset
        for (int unsigned i = 0; i < N; i++)
            push_op(i, W'(10 * i + 1), W'(i + 2), i[0]);
        rsp_ready = '1;
        drive();
        @(negedge Clock);
        #1;
        check("rst_ready", 32'(ReqReady), 32'd0);
        check("rst_valid", 32'(RspValid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_data", 32'(RspData), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int unsigned k = 0; k < N; k++) begin
            tick();
            check("full_grant", 32'(samp_ready), 32'd1 << k);
        end
        tick();
        check("full_done", sb.size(), 32'd0);

        // Single add
        push_op(0, 8'd5, 8'd3, 1'b0);
        tick();
        check("add_ready", 32'(samp_ready), 32'h1);
        tick();
        check("add_data", 32'(samp_data), 32'd8);

        // Subtract wrap and add wrap
        push_op(1, 8'd3, 8'd5, 1'b1);
        tick();
        check("sub_ready", 32'(samp_ready), 32'h2);
        tick();
        check("sub_data", 32'(samp_data), 32'hFE);
        push_op(1, 8'h80, 8'h80, 1'b0);
        tick();
        tick();
        check("wrap_data", 32'(samp_data), 32'h00);

        // Backpressure on requester 2 while requester 1 waits
        rsp_ready = 4'b1011;
        push_op(2, 8'h11, 8'h22, 1'b0);
        tick();
        check("bp_grant2", 32'(samp_ready), 32'h4);
        push_op(1, 8'd9, 8'd4, 1'b1);
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            check("bp_ready_low", 32'(samp_ready), 32'h0);
            check("bp_data_hold", 32'(samp_data), 32'h33);
        end
        rsp_ready = '1;
        tick();
        check("bp_release", 32'(samp_ready), 32'h2);
        tick();
        check("bp_next_data", 32'(samp_data), 32'd5);

        // Fairness between requesters 0 and 3
        do_reset();
        for (int unsigned k = 0; k < 4; k++) begin
            push_op(0, W'(k), 8'd1, 1'b0);
            push_op(3, W'(k), 8'd1, 1'b1);
        end
        rsp_ready = '1;
        for (int unsigned k = 0; k < 8; k++) begin
            tick();
            check("fair_grant", 32'(samp_ready), (k % 2 == 0) ? 32'h1 : 32'h8);
        end
        drain();

        // Reset while a result is held
        push_op(2, 8'd7, 8'd2, 1'b0);
        rsp_ready = '0;
        tick();
        check("mid_grant", 32'(samp_ready), 32'h4);
        #2;
        Reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(RspValid), 32'd0);
        check("mid_rst_data", 32'(RspData), 32'd0);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        clear_all();
        for (int unsigned i = 0; i < N; i++) push_op(i, W'(i), W'(i), 1'b0);
        @(negedge Clock);
        Reset = 1'b1;
        rsp_ready = '1;
        tick();
        check("post_rst_grant", 32'(samp_ready), 32'h1);
        drain();

        // Random traffic with random backpressure
        for (int unsigned k = 0; k < 300; k++) begin
            int unsigned r;
            r = $urandom_range(N - 1);
            if (opq[r].size() < 3 && $urandom_range(3) != 0)
                push_op(r, W'($urandom), W'($urandom), 1'($urandom));
            rsp_ready = N'($urandom);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
